// File: rtl/compare_job_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : compare_job_sequencer_if
// Description : Bundles the operand handshake, comparator operand/flag lines,
//               result handshake and job counter for compare_job_sequencer.
//               master = upstream/downstream/comparator side,
//               slave  = the sequencer itself.
// Revision    : 1.0 - initial release
// ============================================================================
interface compare_job_sequencer_if #(
  parameter int N = 3
);
  logic         in_valid;
  logic         in_ready;
  logic [N:0]   in_a;
  logic [N:0]   in_b;
  logic [N:0]   a_out;
  logic [N:0]   b_out;
  logic         cmp_less;
  logic         cmp_equal;
  logic         cmp_greater;
  logic         cmp_solved;
  logic         res_valid;
  logic         res_ready;
  logic [1:0]   res_code;
  logic [7:0]   job_cnt;

  modport master (
    output in_valid, in_a, in_b,
    output cmp_less, cmp_equal, cmp_greater, cmp_solved,
    output res_ready,
    input  in_ready, a_out, b_out, res_valid, res_code, job_cnt
  );

  modport slave (
    input  in_valid, in_a, in_b,
    input  cmp_less, cmp_equal, cmp_greater, cmp_solved,
    input  res_ready,
    output in_ready, a_out, b_out, res_valid, res_code, job_cnt
  );
endinterface
`default_nettype wire

// File: rtl/compare_job_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : compare_job_sequencer
// Description : Sequences one compare job at a time: captures an operand pair,
//               drives it to an external comparator, waits for the solved
//               flags and presents a 2-bit result code downstream.
//               Optional macro CMP_TIMEOUT_EN adds a WAIT-state timeout that
//               reports code 11 after TIMEOUT unsolved WAIT cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module compare_job_sequencer #(
  parameter int N       = 3,
  parameter int TIMEOUT = 8
) (
  input  logic                    clock_i,
  input  logic                    reset_i,
  compare_job_sequencer_if.slave  port_io
);

  localparam logic [1:0] CODE_EQ  = 2'b00;
  localparam logic [1:0] CODE_LT  = 2'b01;
  localparam logic [1:0] CODE_GT  = 2'b10;
  localparam logic [1:0] CODE_ERR = 2'b11;

  // Elaboration-time guard on the timeout range (the counter is 8 bits wide).
  if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
    $error("compare_job_sequencer: TIMEOUT must be in 2..255");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic [N:0] a_q, a_d;
  logic [N:0] b_q, b_d;
  logic [1:0] code_q, code_d;
  logic [7:0] job_q, job_d;
  logic [1:0] flag_code;

`ifdef CMP_TIMEOUT_EN
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);
  logic [7:0] wcnt_q, wcnt_d;
`endif

  // Decode the comparator flags; anything other than exactly one flag is an error.
  always_comb begin
    flag_code = CODE_ERR;
    case ({port_io.cmp_greater, port_io.cmp_equal, port_io.cmp_less})
      3'b001:  flag_code = CODE_LT;
      3'b010:  flag_code = CODE_EQ;
      3'b100:  flag_code = CODE_GT;
      default: flag_code = CODE_ERR;
    endcase
  end

  // Next-state logic; flags only matter in WAIT, so stale flags are ignored elsewhere.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    code_d  = code_q;
    job_d   = job_q;
`ifdef CMP_TIMEOUT_EN
    wcnt_d  = wcnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (port_io.in_valid) begin
          a_d     = port_io.in_a;
          b_d     = port_io.in_b;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
`ifdef CMP_TIMEOUT_EN
        wcnt_d  = 8'd0;
`endif
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (port_io.cmp_solved) begin
          code_d  = flag_code;
          state_d = S_DONE;
        end
`ifdef CMP_TIMEOUT_EN
        else if (wcnt_q == WAIT_LAST) begin
          code_d  = CODE_ERR;
          state_d = S_DONE;
        end else begin
          wcnt_d  = wcnt_q + 8'd1;
        end
`endif
      end
      S_DONE: begin
        if (port_io.res_ready) begin
          job_d   = job_q + 8'd1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset that discards any job.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      code_q  <= 2'b00;
      job_q   <= 8'd0;
`ifdef CMP_TIMEOUT_EN
      wcnt_q  <= 8'd0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      code_q  <= code_d;
      job_q   <= job_d;
`ifdef CMP_TIMEOUT_EN
      wcnt_q  <= wcnt_d;
`endif
    end
  end

  assign port_io.in_ready  = (state_q == S_IDLE);
  assign port_io.res_valid = (state_q == S_DONE);
  assign port_io.a_out     = a_q;
  assign port_io.b_out     = b_q;
  assign port_io.res_code  = code_q;
  assign port_io.job_cnt   = job_q;

endmodule
`default_nettype wire

// File: tb/tb_compare_job_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_compare_job_sequencer
// Description : Scoreboard bench for compare_job_sequencer. The driver pushes
//               the expected result (code, operands, DONE cycle) for every job;
//               a monitor pops and compares when res_valid first appears.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_compare_job_sequencer;

  logic clk;
  logic rst;
  int   cyc;
  int   n_checks;
  int   n_fail;
  logic [7:0] exp_cnt;

  typedef struct {
    logic [1:0] code;
    logic [3:0] a;
    logic [3:0] b;
    int         cyc;
  } exp_t;

  exp_t sbq[$];

  compare_job_sequencer_if #(.N(3)) bus ();

  compare_job_sequencer #(.N(3), .TIMEOUT(8)) dut (
    .clock_i (clk),
    .reset_i (rst),
    .port_io (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic set_flags(input logic [3:0] f);  // {solved, greater, equal, less}
    bus.cmp_solved  = f[3];
    bus.cmp_greater = f[2];
    bus.cmp_equal   = f[1];
    bus.cmp_less    = f[0];
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_cnt = 8'd0;
    chk("rst_in_ready",  32'(bus.in_ready),  1);
    chk("rst_res_valid", 32'(bus.res_valid), 0);
    chk("rst_res_code",  32'(bus.res_code),  0);
    chk("rst_a_out",     32'(bus.a_out),     0);
    chk("rst_b_out",     32'(bus.b_out),     0);
    chk("rst_job_cnt",   32'(bus.job_cnt),   0);
  endtask

  // Present a pair, wait (bounded) for in_ready, return cycle number right after the accepting edge.
  task automatic handshake(input logic [3:0] a, input logic [3:0] b, output int h);
    bit ok;
    ok = 1'b0;
    bus.in_a = a;
    bus.in_b = b;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("handshake_timeout", 0, 1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    h = cyc;
  endtask

  task automatic run_job(input logic [3:0] a, input logic [3:0] b, input int d,
                         input logic [3:0] flags, input bit stale, input int hold,
                         input logic [1:0] code, input logic [3:0] sa, input logic [3:0] sb);
    int   h;
    exp_t e;
    handshake(a, b, h);
    e.code = code; e.a = a; e.b = b; e.cyc = h + 2 + d;
    sbq.push_back(e);
    // LOAD cycle
    chk("load_in_ready", 32'(bus.in_ready), 0);
    if (stale) set_flags(4'b1001);
    @(posedge clk); #1;
    // first WAIT cycle
    set_flags(4'b0000);
    for (int i = 0; i < d; i++) begin
      @(posedge clk); #1;
      chk("wait_res_valid", 32'(bus.res_valid), 0);
    end
    set_flags(flags);
    @(posedge clk); #1;
    set_flags(4'b0000);
    chk("done_res_valid", 32'(bus.res_valid), 1);
    if (hold > 0) begin
      bus.in_a = sa;
      bus.in_b = sb;
      bus.in_valid = 1'b1;
      for (int i = 0; i < hold; i++) begin
        @(posedge clk); #1;
        chk("stall_in_ready",  32'(bus.in_ready),  0);
        chk("stall_res_valid", 32'(bus.res_valid), 1);
        chk("stall_res_code",  32'(bus.res_code),  32'(code));
        chk("stall_a_out",     32'(bus.a_out),     32'(a));
        chk("stall_b_out",     32'(bus.b_out),     32'(b));
      end
    end
    bus.res_ready = 1'b1;
    @(posedge clk); #1;
    bus.res_ready = 1'b0;
    exp_cnt = exp_cnt + 8'd1;
    chk("job_cnt",        32'(bus.job_cnt),   32'(exp_cnt));
    chk("idle_res_valid", 32'(bus.res_valid), 0);
    chk("idle_in_ready",  32'(bus.in_ready),  1);
  endtask

  // Monitor: compare against the scoreboard the first cycle res_valid is seen per job.
  initial begin
    exp_t e;
    bit   seen;
    seen = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        seen = 1'b0;
      end else if (bus.res_valid && !seen) begin
        seen = 1'b1;
        if (sbq.size() == 0) begin
          chk("unexpected_result", 1, 0);
        end else begin
          e = sbq.pop_front();
          chk("mon_res_code", 32'(bus.res_code), 32'(e.code));
          chk("mon_a_out",    32'(bus.a_out),    32'(e.a));
          chk("mon_b_out",    32'(bus.b_out),    32'(e.b));
          chk("mon_latency",  32'(cyc),          32'(e.cyc));
        end
      end else if (!bus.res_valid) begin
        seen = 1'b0;
      end
    end
  end

  initial begin
    int   h;
    exp_t e;
    n_checks = 0;
    n_fail   = 0;
    exp_cnt  = 8'd0;
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_a = 4'h0;
    bus.in_b = 4'h0;
    bus.res_ready = 1'b0;
    set_flags(4'b0000);
    repeat (3) @(posedge clk);
    #1;
    do_reset();

    // greater, solved in first WAIT cycle
    run_job(4'h9, 4'h4, 0, 4'b1100, 1'b0, 0, 2'b10, 4'h0, 4'h0);
    // equal, solved 2 cycles into WAIT, stale less flags during LOAD
    run_job(4'h6, 4'h6, 2, 4'b1010, 1'b1, 0, 2'b00, 4'h0, 4'h0);
    // less and greater together -> error
    run_job(4'h3, 4'h7, 0, 4'b1101, 1'b0, 0, 2'b11, 4'h0, 4'h0);
    // less after one unsolved WAIT cycle
    run_job(4'h2, 4'hA, 1, 4'b1001, 1'b0, 0, 2'b01, 4'h0, 4'h0);
    // solved with no flag -> error
    run_job(4'h5, 4'h5, 0, 4'b1000, 1'b0, 0, 2'b11, 4'h0, 4'h0);
    // 10-cycle stall in DONE with the next pair already offered
    run_job(4'h8, 4'h1, 0, 4'b1100, 1'b0, 10, 2'b10, 4'h3, 4'hC);
    run_job(4'h3, 4'hC, 0, 4'b1001, 1'b0, 0, 2'b01, 4'h0, 4'h0);

`ifdef CMP_TIMEOUT_EN
    // never solved: 8 WAIT cycles then error
    run_job(4'hE, 4'hE, 7, 4'b0000, 1'b0, 0, 2'b11, 4'h0, 4'h0);
`else
    // never solved: sequencer stays in WAIT
    handshake(4'hE, 4'hE, h);
    repeat (100) @(posedge clk);
    #1;
    chk("no_timeout_res_valid", 32'(bus.res_valid), 0);
    chk("no_timeout_in_ready",  32'(bus.in_ready),  0);
    do_reset();
`endif

    // reset during WAIT
    handshake(4'h5, 4'h3, h);
    @(posedge clk); #1;
    @(posedge clk); #1;
    do_reset();

    // reset during DONE
    run_job(4'h1, 4'h2, 0, 4'b1001, 1'b0, 0, 2'b01, 4'h0, 4'h0);
    handshake(4'hC, 4'h2, h);
    e.code = 2'b10; e.a = 4'hC; e.b = 4'h2; e.cyc = h + 2;
    sbq.push_back(e);
    @(posedge clk); #1;
    set_flags(4'b1100);
    @(posedge clk); #1;
    set_flags(4'b0000);
    chk("pre_rst_done_valid", 32'(bus.res_valid), 1);
    @(negedge clk); #1;
    do_reset();

    // 256 jobs: job_cnt wraps back to 0
    for (int i = 0; i < 256; i++) begin
      run_job(4'(i), 4'(i), 0, 4'b1010, 1'b0, 0, 2'b00, 4'h0, 4'h0);
    end
    chk("job_cnt_wrap", 32'(bus.job_cnt), 0);

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", 32'(sbq.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/compare_job_sequencer.md
COMPARE_JOB_SEQUENCER -- requirements
Module: compare_job_sequencer

Interface
REQ-001 SHALL have parameter N, default 3, operand MSB index (operand width N+1).
REQ-002 SHALL have parameter TIMEOUT, default 8, maximum WAIT cycles before error (legal 2..255).
REQ-003 clock  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  upstream operand pair valid.
REQ-006 in_ready  output  1  sequencer can accept a pair.
REQ-007 in_a, in_b  input  N+1 each  operands.
REQ-008 a_out, b_out  output  N+1 each  registered operands driven to comparator a_in/b_in.
REQ-009 cmp_less, cmp_equal, cmp_greater, cmp_solved  input  1 each  comparator result flags.
REQ-010 res_valid  output  1  result available downstream.
REQ-011 res_ready  input  1  downstream accepts result.
REQ-012 res_code  output  2  00 equal, 01 less, 10 greater, 11 error.
REQ-013 job_cnt  output  8  count of completed jobs (wraps 255->0).

Function
REQ-014 SHALL implement FSM IDLE, LOAD, WAIT, DONE.
REQ-015 IDLE: in_ready=1; in_valid&in_ready SHALL capture in_a/in_b into a_out/b_out and go to LOAD next cycle.
REQ-016 LOAD: one cycle, in_ready=0, a_out/b_out held, WAIT counter cleared to 0; next state WAIT (lets comparator register operands).
REQ-017 WAIT: cmp_* flags SHALL be sampled only in WAIT; flags seen in IDLE/LOAD/DONE are ignored (stale).
REQ-018 WAIT with cmp_solved=1 and exactly one of less/equal/greater set SHALL register the matching res_code and go to DONE.
REQ-019 WAIT with cmp_solved=1 and zero or more than one flag set SHALL register res_code=11 and go to DONE.
REQ-020 WAIT with cmp_solved=0 SHALL increment the WAIT counter and remain in WAIT (timeout per REQ-027).
REQ-021 DONE: res_valid=1, res_code stable; res_ready=1 SHALL increment job_cnt and go to IDLE next cycle.
REQ-022 Minimum latency from accepted in_valid to res_valid SHALL be 3 cycles (IDLE->LOAD->WAIT->DONE).
REQ-023 in_ready SHALL be 1 only in IDLE; no new pair accepted while a job is outstanding.
REQ-024 res_valid held with res_ready=0 SHALL keep res_code and a_out/b_out unchanged indefinitely.
REQ-025 a_out/b_out SHALL change only on an IDLE handshake.

Reset
REQ-026 reset SHALL, in any state (including mid-job), force IDLE and clear a_out, b_out, res_code, job_cnt, WAIT counter to 0, res_valid=0; in_ready=1 the cycle after reset deasserts; any in-flight job is discarded.

Configuration
REQ-027 Macro CMP_TIMEOUT_EN: when defined, WAIT reaching counter value TIMEOUT-1 with cmp_solved=0 SHALL register res_code=11 and go to DONE; when undefined, no counter logic exists and WAIT waits for cmp_solved indefinitely.

Verification
REQ-028 N=3: in_a=0x9, in_b=0x4, cmp_greater&cmp_solved in first WAIT cycle -> res_valid 3 cycles after handshake, res_code=10, job_cnt 0->1 on res_ready.
REQ-029 in_a=in_b=0x6, cmp_equal&cmp_solved asserted 2 cycles into WAIT -> res_code=00, res_valid on 5th cycle after handshake.
REQ-030 cmp_less=cmp_greater=1 with cmp_solved in WAIT -> res_code=11.
REQ-031 CMP_TIMEOUT_EN defined, TIMEOUT=8, cmp_solved held 0 -> res_code=11 after 8 WAIT cycles; undefined -> stays in WAIT, res_valid=0 after 100 cycles.
REQ-032 res_ready=0 for 10 cycles in DONE with in_valid=1 -> in_ready=0, res_code/a_out stable; then res_ready=1 -> IDLE, next pair accepted.
REQ-033 reset asserted during WAIT and during DONE -> next cycle IDLE, res_valid=0, all outputs 0; 256 completed jobs -> job_cnt wraps to 0.
